bf_fetch_unit: RTL

- Instruction fetch and sequencing stage; feeds the control decoder one `op_code` per cycle.
- Owns the program counter and drives the synchronous instruction-memory read address.
- Handles backward loop redirects (`CBB` taken, target PC from the loop cache) and forward bracket skipping (`CBF` taken with zero accumulator) by scanning to the matching `CBB` with a nesting-depth counter.
- Signals program completion and structural errors.

---
 rtl/bf_fetch_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bf_fetch_unit.sv
// Instruction fetch/sequencer: owns the PC, scans forward over skipped brackets, flags done/error.
// Latency: imem_addr_o is combinational next-PC, so instr_o is valid the cycle after start/redirect (zero-bubble jumps).
// Backpressure: stall_i holds the PC and re-reads the same address; stall_i is ignored while scanning a skipped block.
// Optional feature macro: BF_FETCH_PERF_EN adds issued/skipped cycle counters.
module bf_fetch_unit #(
   parameter int PC_WIDTH    = 16,
   parameter int DEPTH_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [PC_WIDTH-1:0] prog_len_i,
   output logic [PC_WIDTH-1:0] imem_addr_o,
   input  logic [3:0]          imem_rdata_i,
   input  logic                stall_i,
   input  logic                jump_back_i,
   input  logic [PC_WIDTH-1:0] jump_target_i,
   input  logic                skip_fwd_i,
   output logic [3:0]          instr_o,
   output logic                instr_valid_o,
   output logic [PC_WIDTH-1:0] pc_o,
   output logic                done_o,
   output logic                err_o
`ifdef BF_FETCH_PERF_EN
   ,
   output logic [31:0]         issued_cnt_o,
   output logic [31:0]         skipped_cnt_o
`endif
);

   // Op-code encoding shared with the control decoder.
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_CBF = 4'd7;
   localparam logic [3:0] OP_CBB = 4'd8;

   localparam logic [PC_WIDTH-1:0]    PC_ZERO   = '0;
   localparam logic [PC_WIDTH-1:0]    PC_ONE    = PC_WIDTH'(1);
   localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = DEPTH_WIDTH'(1);
   localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SKIP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
   logic                   err_q;
   logic                   err_set, err_clr;
   logic                   at_end;

   // pc_q is the address whose data is on imem_rdata_i right now.
   assign at_end        = (pc_q == prog_len_i);
   assign instr_valid_o = (state_q == ST_RUN) && !at_end;
   assign instr_o       = instr_valid_o ? imem_rdata_i : OP_NOP;
   assign pc_o          = pc_q;
   assign done_o        = (state_q == ST_DONE);
   assign err_o         = err_q;
   // Presenting next-PC directly as the read address makes redirects free.
   assign imem_addr_o   = pc_d;

   // Next-state / next-PC selection; redirect inputs only matter on a valid RUN cycle.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      err_set = 1'b0;
      err_clr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            pc_d = PC_ZERO;
            if (start_i) begin
               state_d = ST_RUN;
               err_clr = 1'b1;
            end
         end
         ST_RUN: begin
            if (at_end) begin
               state_d = ST_DONE;
            end else if (stall_i) begin
               pc_d = pc_q;
            end else if (jump_back_i) begin
               // Jump has priority; a simultaneous skip is a decoder fault.
               pc_d = jump_target_i;
               if (skip_fwd_i) begin
                  err_set = 1'b1;
               end
            end else if (skip_fwd_i) begin
               state_d = ST_SKIP;
               depth_d = DEPTH_ONE;
               pc_d    = pc_q + PC_ONE;
            end else begin
               pc_d = pc_q + PC_ONE;
            end
         end
         ST_SKIP: begin
            if (at_end) begin
               // Ran off the program without finding the matching CBB.
               state_d = ST_DONE;
               err_set = 1'b1;
            end else if (imem_rdata_i == OP_CBF) begin
               if (depth_q == DEPTH_MAX) begin
                  // Nesting deeper than the counter can track; refuse to wrap.
                  state_d = ST_DONE;
                  err_set = 1'b1;
               end else begin
                  depth_d = depth_q + DEPTH_ONE;
                  pc_d    = pc_q + PC_ONE;
               end
            end else if (imem_rdata_i == OP_CBB) begin
               pc_d = pc_q + PC_ONE;
               if (depth_q == DEPTH_ONE) begin
                  state_d = ST_RUN;
                  depth_d = '0;
               end else begin
                  depth_d = depth_q - DEPTH_ONE;
               end
            end else begin
               pc_d = pc_q + PC_ONE;
            end
         end
         ST_DONE: begin
            if (start_i) begin
               state_d = ST_RUN;
               pc_d    = PC_ZERO;
               err_clr = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            pc_d    = PC_ZERO;
         end
      endcase
   end

   // Sequencer state, PC, nesting depth and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= PC_ZERO;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
         if (err_clr) begin
            err_q <= 1'b0;
         end else if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

`ifdef BF_FETCH_PERF_EN
   logic [31:0] issued_q;
   logic [31:0] skipped_q;

   assign issued_cnt_o  = issued_q;
   assign skipped_cnt_o = skipped_q;

   // Saturating counters of consumed instructions and scan cycles; cleared per run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued_q  <= '0;
         skipped_q <= '0;
      end else if (start_i) begin
         issued_q  <= '0;
         skipped_q <= '0;
      end else begin
         if (instr_valid_o && !stall_i && (issued_q != 32'hFFFF_FFFF)) begin
            issued_q <= issued_q + 32'd1;
         end
         if ((state_q == ST_SKIP) && (skipped_q != 32'hFFFF_FFFF)) begin
            skipped_q <= skipped_q + 32'd1;
         end
      end
   end
`endif

endmodule
